// File: rtl/i2c_bus_monitor_pkg.sv
// Shared types for the passive I2C bus monitor: FSM states and the per-byte record.
package i2c_bus_monitor_pkg;

    localparam int unsigned REC_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BITS = 2'd1,
        ACK  = 2'd2
    } fsm_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       ack;
        logic       is_addr;
        logic       rw;
        logic       err;
    } i2c_mon_rec_s;

    // Left-align the n valid bits of a truncated byte, dropping a trailing framing-clock bit.
    function automatic logic [7:0] align_partial(input logic [7:0] shreg,
                                                 input logic       drop_last,
                                                 input logic [3:0] n);
        return 8'((shreg >> drop_last) << (4'd8 - n));
    endfunction

endpackage

// File: rtl/i2c_mon_rec_fifo.sv
// First-word-fall-through FIFO of monitor records; extra pointer bit separates full from empty.
module i2c_mon_rec_fifo
    import i2c_bus_monitor_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  i2c_mon_rec_s wdata,
    input  logic         pop,
    output i2c_mon_rec_s rdata,
    output logic         empty,
    output logic         full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [REC_W-1:0] mem_q [DEPTH];
    logic [REC_W-1:0] mem_d [DEPTH];
    logic             wr_en;
    logic             rd_en;

    // A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(rd_en);
        mem_d    = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = REC_W'(wdata);
        end
        rdata = empty ? '0 : i2c_mon_rec_s'(mem_q[rd_ptr_q[AW-1:0]]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/i2c_bus_monitor_sampler.sv
// Passive I2C frame decoder: synchronise SCL/SDA, detect START/STOP, deserialise bytes into a record FIFO.
// Optional glitch filter on the synchronised lines: define I2C_MON_GLITCH_FILTER_EN.
module i2c_bus_monitor_sampler
    import i2c_bus_monitor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned GLITCH_CYCLES = 3
) (
    input  logic             pclk,
    input  logic             areset,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [7:0]       rec_data,
    output logic             rec_ack,
    output logic             rec_is_addr,
    output logic             rec_rw,
    output logic             rec_err,
    output logic             bus_busy,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic [1:0]             line_s;
    logic [1:0]             line_f;
    logic [1:0]             line_prev_q, line_prev_d;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        line_s     = {sda_sync_q[SYNC_STAGES-1], scl_sync_q[SYNC_STAGES-1]};
        line_prev_d = line_f;
    end

    // Lines idle high, so synchronisers and the edge reference preset to 1.
    always_ff @(posedge pclk) begin
        if (areset) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            line_prev_q <= '1;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            line_prev_q <= line_prev_d;
        end
    end

`ifdef I2C_MON_GLITCH_FILTER_EN
    localparam int unsigned GCW = $clog2(GLITCH_CYCLES + 1);

    logic [1:0]          filt_q, filt_d;
    logic [1:0][GCW-1:0] gcnt_q, gcnt_d;

    // Output follows the input only after GLITCH_CYCLES consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        gcnt_d = gcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (line_s[i] != filt_q[i]) begin
                if (gcnt_q[i] == GCW'(GLITCH_CYCLES - 1)) begin
                    filt_d[i] = line_s[i];
                    gcnt_d[i] = '0;
                end else begin
                    gcnt_d[i] = gcnt_q[i] + GCW'(1);
                end
            end else begin
                gcnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (areset) begin
            filt_q <= '1;
            gcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            gcnt_q <= gcnt_d;
        end
    end

    assign line_f = filt_q;
`else
    assign line_f = line_s;

    if (GLITCH_CYCLES == 0) begin : g_glitch_cfg_unused
    end
`endif

    logic scl, sda, scl_prev, sda_prev;
    logic scl_rise, scl_fall, start_det, stop_det;

    // SCL edges win over SDA edges in the same cycle, so START/STOP need SCL steady high.
    always_comb begin
        scl       = line_f[0];
        sda       = line_f[1];
        scl_prev  = line_prev_q[0];
        sda_prev  = line_prev_q[1];
        scl_rise  = scl && !scl_prev;
        scl_fall  = !scl && scl_prev;
        start_det = scl && scl_prev && sda_prev && !sda;
        stop_det  = scl && scl_prev && !sda_prev && sda;
    end

    fsm_state_e   state_q, state_d;
    logic [7:0]   shreg_q, shreg_d;
    logic [3:0]   bit_cnt_q, bit_cnt_d;
    logic         hi_bit_q, hi_bit_d;
    logic         is_first_q, is_first_d;
    logic         rw_q, rw_d;
    logic         busy_q, busy_d;
    logic         push_q, push_d;
    i2c_mon_rec_s rec_q, rec_d;
    logic [3:0]   n_bits;
    logic         rw_eff;

    // hi_bit marks a bit sampled in the current SCL-high phase; if START/STOP follows in that
    // same phase the clock was a framing clock, so that bit is not counted as data.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        hi_bit_d   = hi_bit_q;
        is_first_d = is_first_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        push_d     = 1'b0;
        rec_d      = rec_q;
        n_bits     = bit_cnt_q - {3'b000, hi_bit_q};
        rw_eff     = is_first_q ? shreg_q[0] : rw_q;

        if (scl_fall) begin
            hi_bit_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_det) begin
                    state_d    = BITS;
                    is_first_d = 1'b1;
                    bit_cnt_d  = '0;
                    hi_bit_d   = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            BITS, ACK: begin
                if (start_det || stop_det) begin
                    if (n_bits != 4'd0) begin
                        push_d        = 1'b1;
                        rec_d.data    = align_partial(shreg_q, hi_bit_q, n_bits);
                        rec_d.ack     = 1'b0;
                        rec_d.is_addr = is_first_q;
                        rec_d.rw      = rw_q;
                        rec_d.err     = 1'b1;
                    end
                    bit_cnt_d = '0;
                    hi_bit_d  = 1'b0;
                    if (start_det) begin
                        state_d    = BITS;
                        is_first_d = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        is_first_d = 1'b0;
                        busy_d     = 1'b0;
                    end
                end else if (scl_rise) begin
                    if (state_q == BITS) begin
                        shreg_d   = {shreg_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        hi_bit_d  = 1'b1;
                        if (bit_cnt_q == 4'd7) begin
                            state_d = ACK;
                        end
                    end else begin
                        push_d        = 1'b1;
                        rec_d.data    = shreg_q;
                        rec_d.ack     = !sda;
                        rec_d.is_addr = is_first_q;
                        rec_d.rw      = rw_eff;
                        rec_d.err     = 1'b0;
                        rw_d          = rw_eff;
                        is_first_d    = 1'b0;
                        bit_cnt_d     = '0;
                        hi_bit_d      = 1'b0;
                        state_d       = BITS;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (areset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            hi_bit_q   <= 1'b0;
            is_first_q <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            push_q     <= 1'b0;
            rec_q      <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            hi_bit_q   <= hi_bit_d;
            is_first_q <= is_first_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            push_q     <= push_d;
            rec_q      <= rec_d;
        end
    end

    i2c_mon_rec_s head;
    logic         fifo_empty;
    logic         fifo_full;

    i2c_mon_rec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (pclk),
        .rst   (areset),
        .push  (push_q),
        .wdata (rec_q),
        .pop   (rec_ready),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             drop;

    // A record is lost only when the FIFO is full and nothing is popped in the same cycle.
    always_comb begin
        drop       = push_q && fifo_full && !(rec_ready && !fifo_empty);
        overflow_d = overflow_q || drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (areset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign rec_valid   = !fifo_empty;
    assign rec_data    = head.data;
    assign rec_ack     = head.ack;
    assign rec_is_addr = head.is_addr;
    assign rec_rw      = head.rw;
    assign rec_err     = head.err;
    assign bus_busy    = busy_q;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_i2c_bus_monitor_sampler.sv
// Directed bench for i2c_bus_monitor_sampler: table-driven frames plus overflow, truncation, reset and latency sequences.
module tb_i2c_bus_monitor_sampler;
    import i2c_bus_monitor_pkg::*;

    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned FIFO_DEPTH    = 8;
    localparam int unsigned CNT_W         = 8;
    localparam int unsigned GLITCH_CYCLES = 3;
    localparam int          HOLD          = 6;
`ifdef I2C_MON_GLITCH_FILTER_EN
    localparam int          LAT_EXP       = SYNC_STAGES + 2 + GLITCH_CYCLES;
`else
    localparam int          LAT_EXP       = SYNC_STAGES + 2;
`endif

    logic             pclk = 1'b0;
    logic             areset;
    logic             scl_i;
    logic             sda_i;
    logic             rec_valid;
    logic             rec_ready;
    logic [7:0]       rec_data;
    logic             rec_ack;
    logic             rec_is_addr;
    logic             rec_rw;
    logic             rec_err;
    logic             bus_busy;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    i2c_bus_monitor_sampler #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .CNT_W         (CNT_W),
        .GLITCH_CYCLES (GLITCH_CYCLES)
    ) dut (
        .pclk        (pclk),
        .areset      (areset),
        .scl_i       (scl_i),
        .sda_i       (sda_i),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_data    (rec_data),
        .rec_ack     (rec_ack),
        .rec_is_addr (rec_is_addr),
        .rec_rw      (rec_rw),
        .rec_err     (rec_err),
        .bus_busy    (bus_busy),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    typedef enum int {OP_START, OP_BYTE, OP_RSTART, OP_STOP} op_e;

    typedef struct {
        op_e          op;
        logic [7:0]   bval;
        logic         ack;
        i2c_mon_rec_s exp;
    } vec_s;

    function automatic vec_s mk(input op_e op, input logic [7:0] b, input logic a,
                                input logic [7:0] d, input logic ea, input logic ia,
                                input logic rw, input logic err);
        vec_s v;
        v.op          = op;
        v.bval        = b;
        v.ack         = a;
        v.exp.data    = d;
        v.exp.ack     = ea;
        v.exp.is_addr = ia;
        v.exp.rw      = rw;
        v.exp.err     = err;
        return v;
    endfunction

    function automatic i2c_mon_rec_s mkrec(input logic [7:0] d, input logic a, input logic ia,
                                           input logic rw, input logic err);
        i2c_mon_rec_s r;
        r.data    = d;
        r.ack     = a;
        r.is_addr = ia;
        r.rw      = rw;
        r.err     = err;
        return r;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Bus drivers: called at a negedge, SDA only moves while SCL is low except for START/STOP.
    task automatic bus_start();
        sda_i = 1'b0; wait_cyc(HOLD);
        scl_i = 1'b0; wait_cyc(HOLD);
    endtask

    task automatic bus_bit(input logic b);
        sda_i = b;    wait_cyc(HOLD);
        scl_i = 1'b1; wait_cyc(HOLD);
        scl_i = 1'b0; wait_cyc(HOLD);
    endtask

    task automatic bus_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) bus_bit(b[i]);
        bus_bit(!ack);
    endtask

    task automatic bus_rstart();
        sda_i = 1'b1; wait_cyc(HOLD);
        scl_i = 1'b1; wait_cyc(HOLD);
        sda_i = 1'b0; wait_cyc(HOLD);
        scl_i = 1'b0; wait_cyc(HOLD);
    endtask

    task automatic bus_stop();
        sda_i = 1'b0; wait_cyc(HOLD);
        scl_i = 1'b1; wait_cyc(HOLD);
        sda_i = 1'b1; wait_cyc(HOLD);
    endtask

    // Sends a byte and counts pclk edges from the raw ACK-bit SCL rise until rec_valid shows.
    task automatic bus_byte_lat(input logic [7:0] b, input logic ack, output int lat);
        for (int i = 7; i >= 0; i--) bus_bit(b[i]);
        sda_i = !ack; wait_cyc(HOLD);
        scl_i = 1'b1;
        lat   = 0;
        while (!rec_valid && lat < 40) begin
            @(posedge pclk);
            #1;
            lat++;
        end
        @(negedge pclk);
        wait_cyc(HOLD);
        scl_i = 1'b0; wait_cyc(HOLD);
    endtask

    task automatic pop_check(input string name, input i2c_mon_rec_s e);
        int          w;
        logic [11:0] got;
        w = 0;
        while (!rec_valid && w < 50) begin
            wait_cyc(1);
            w++;
        end
        got = {rec_data, rec_ack, rec_is_addr, rec_rw, rec_err};
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s: got valid=%b data=%02h ack=%b addr=%b rw=%b err=%b expected data=%02h ack=%b addr=%b rw=%b err=%b",
                     name, rec_valid, rec_data, rec_ack, rec_is_addr, rec_rw, rec_err,
                     e.data, e.ack, e.is_addr, e.rw, e.err);
        end
        rec_ready = 1'b1;
        wait_cyc(1);
        rec_ready = 1'b0;
    endtask

    vec_s         vecs [7];
    i2c_mon_rec_s exp_q [$];
    int           lat;
    int           k;
    logic [7:0]   bv;

    initial begin
        vecs[0] = mk(OP_START,  8'hA4, 1'b1, 8'hA4, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[1] = mk(OP_BYTE,   8'h5C, 1'b1, 8'h5C, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[2] = mk(OP_STOP,   8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[3] = mk(OP_START,  8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[4] = mk(OP_BYTE,   8'h3F, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[5] = mk(OP_RSTART, 8'hA4, 1'b1, 8'hA4, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[6] = mk(OP_STOP,   8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        areset    = 1'b1;
        scl_i     = 1'b1;
        sda_i     = 1'b1;
        rec_ready = 1'b0;
        wait_cyc(3);
        check("reset_outputs",
              32'({rec_valid, rec_data, rec_ack, rec_is_addr, rec_rw, rec_err, bus_busy, overflow, drop_cnt}),
              32'd0);
        areset = 1'b0;
        wait_cyc(5);

        // Write frame, then read frame with repeated START, records held until the drain.
        for (int i = 0; i < 7; i++) begin
            case (vecs[i].op)
                OP_START: begin
                    bus_start();
                    bus_byte(vecs[i].bval, vecs[i].ack);
                    exp_q.push_back(vecs[i].exp);
                    check($sformatf("busy_in_frame_v%0d", i), 32'(bus_busy), 32'd1);
                end
                OP_BYTE: begin
                    bus_byte(vecs[i].bval, vecs[i].ack);
                    exp_q.push_back(vecs[i].exp);
                end
                OP_RSTART: begin
                    bus_rstart();
                    bus_byte(vecs[i].bval, vecs[i].ack);
                    exp_q.push_back(vecs[i].exp);
                end
                default: begin
                    bus_stop();
                    wait_cyc(HOLD);
                    check($sformatf("busy_after_stop_v%0d", i), 32'(bus_busy), 32'd0);
                end
            endcase
        end
        k = 0;
        while (exp_q.size() > 0) begin
            pop_check($sformatf("tbl_rec%0d", k), exp_q.pop_front());
            k++;
        end
        check("tbl_fifo_empty", 32'(rec_valid), 32'd0);

        // STOP after five data bits 10110.
        bus_start();
        bus_byte(8'hA4, 1'b1);
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b1); bus_bit(1'b0);
        bus_stop();
        wait_cyc(HOLD);
        check("trunc_busy", 32'(bus_busy), 32'd0);
        pop_check("trunc_addr", mkrec(8'hA4, 1'b1, 1'b1, 1'b0, 1'b0));
        pop_check("trunc_part", mkrec(8'hB0, 1'b0, 1'b0, 1'b0, 1'b1));
        check("trunc_fifo_empty", 32'(rec_valid), 32'd0);

        // Ten bytes into an eight-deep FIFO with no consumer.
        bus_start();
        for (int i = 0; i < 10; i++) begin
            bv = 8'(8'h30 + 7 * i);
            bus_byte(bv, 1'b1);
        end
        bus_stop();
        wait_cyc(HOLD);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 8; i++) begin
            bv = 8'(8'h30 + 7 * i);
            pop_check($sformatf("ovf_rec%0d", i), mkrec(bv, 1'b1, (i == 0), 1'b0, 1'b0));
        end
        check("ovf_fifo_empty", 32'(rec_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of the second byte.
        bus_start();
        bus_byte(8'h5B, 1'b1);
        bus_bit(1'b1); bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b0);
        check("pre_reset_busy", 32'(bus_busy), 32'd1);
        check("pre_reset_valid", 32'(rec_valid), 32'd1);
        areset = 1'b1;
        scl_i  = 1'b1;
        sda_i  = 1'b1;
        wait_cyc(1);
        check("midframe_reset_outputs",
              32'({rec_valid, rec_data, rec_ack, rec_is_addr, rec_rw, rec_err, bus_busy, overflow, drop_cnt}),
              32'd0);
        areset = 1'b0;
        wait_cyc(12);
        check("post_reset_no_record", 32'({rec_valid, bus_busy}), 32'd0);

        bus_start();
        bus_byte_lat(8'h5B, 1'b1, lat);
        check("ack_latency", 32'(lat), 32'(LAT_EXP));
        bus_byte(8'hC3, 1'b0);
        bus_stop();
        wait_cyc(HOLD);
        pop_check("post_reset_addr", mkrec(8'h5B, 1'b1, 1'b1, 1'b1, 1'b0));
        pop_check("post_reset_data", mkrec(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0));
        check("post_reset_fifo_empty", 32'(rec_valid), 32'd0);

`ifdef I2C_MON_GLITCH_FILTER_EN
        // Two-cycle SDA low pulse with SCL high must not register as START.
        wait_cyc(10);
        sda_i = 1'b0;
        wait_cyc(2);
        sda_i = 1'b1;
        wait_cyc(20);
        check("glitch_busy", 32'(bus_busy), 32'd0);
        check("glitch_no_record", 32'(rec_valid), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
